// File: rtl/fetch_aligner_pkg.sv
// Shared constants and helpers for the fetch aligner and its halfword buffer.
package fetch_aligner_pkg;

  localparam logic [31:0] C_RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned C_HW_W             = 16;
  localparam logic [1:0]  C_RVC_Q3           = 2'b11;

  typedef logic [C_HW_W-1:0] halfword_t;

  // A halfword starts a 16-bit instruction unless its low bits mark quadrant 3.
  function automatic logic f_is_compressed(input halfword_t i_hw, input logic i_cext);
    return i_cext && (i_hw[1:0] != C_RVC_Q3);
  endfunction

  // Instruction length in halfwords for the instruction starting at i_hw.
  function automatic logic [1:0] f_inst_len_hw(input halfword_t i_hw, input logic i_cext);
    return f_is_compressed(i_hw, i_cext) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/fetch_aligner_halfword_buffer.sv
// Three-entry halfword shift buffer: drops 0/1/2 halfwords from the head and
// appends 0/1/2 halfwords behind the survivors in the same cycle.
module halfword_buffer
  import fetch_aligner_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic [1:0]      i_shift_cnt,
  input  logic [1:0]      i_app_cnt,
  input  logic [31:0]     i_app_data,
  output halfword_t       o_hw0,
  output halfword_t       o_hw1,
  output logic [1:0]      o_count
);

  halfword_t  r_hw0, r_hw1, r_hw2;
  logic [1:0] r_count;

  halfword_t  w_nxt0, w_nxt1, w_nxt2;
  logic [1:0] w_base;
  logic [1:0] w_count_nxt;

  // Shift out consumed halfwords first, then drop new ones in at the fill point.
  always_comb begin
    w_nxt0 = r_hw0;
    w_nxt1 = r_hw1;
    w_nxt2 = r_hw2;
    case (i_shift_cnt)
      2'd1: begin
        w_nxt0 = r_hw1;
        w_nxt1 = r_hw2;
        w_nxt2 = '0;
      end
      2'd2: begin
        w_nxt0 = r_hw2;
        w_nxt1 = '0;
        w_nxt2 = '0;
      end
      default: ;
    endcase
    w_base = r_count - i_shift_cnt;
    if (i_app_cnt != 2'd0) begin
      case (w_base)
        2'd0: begin
          w_nxt0 = i_app_data[15:0];
          if (i_app_cnt == 2'd2) w_nxt1 = i_app_data[31:16];
        end
        2'd1: begin
          w_nxt1 = i_app_data[15:0];
          if (i_app_cnt == 2'd2) w_nxt2 = i_app_data[31:16];
        end
        2'd2: w_nxt2 = i_app_data[15:0];
        default: ;
      endcase
    end
    w_count_nxt = i_flush ? 2'd0 : (w_base + i_app_cnt);
  end

  // Buffer storage and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hw0   <= '0;
      r_hw1   <= '0;
      r_hw2   <= '0;
      r_count <= 2'd0;
    end else begin
      r_hw0   <= w_nxt0;
      r_hw1   <= w_nxt1;
      r_hw2   <= w_nxt2;
      r_count <= w_count_nxt;
    end
  end

  assign o_hw0   = r_hw0;
  assign o_hw1   = r_hw1;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_aligner.sv
// Fetch aligner: turns word-aligned fetch data into a stream of whole 16/32-bit
// instructions with their PCs, handling straddling words and redirects.
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter logic [31:0] P_RESET_PC = C_RESET_PC_DEFAULT,
  parameter int unsigned P_C_EXT    = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_fetch_addr,
  input  logic [31:0] i_fetch_data,
  input  logic        i_fetch_valid,
  output logic        o_fetch_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_opcode,
  output logic [31:0] o_pc,
  output logic        o_compressed,
  output logic        o_valid,
  input  logic        i_ready
);

  localparam logic C_CEXT = (P_C_EXT != 0);

  logic [31:0] r_head_pc;
  logic [31:0] r_fetch_addr;
  logic        r_skip;

  halfword_t   w_hw0, w_hw1;
  logic [1:0]  w_count;
  logic        w_compressed;
  logic        w_avail;
  logic        w_consume;
  logic [1:0]  w_cons_hw;
  logic        w_xfer;
  logic [1:0]  w_app_cnt;
  logic [31:0] w_app_data;
  logic [31:0] w_redir_head;
  logic        w_unused_redir_bit0;

  // Bit 0 of a redirect target never matters: instructions are halfword aligned.
  assign w_unused_redir_bit0 = i_redirect_pc[0];

  halfword_buffer u_buf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_redirect),
    .i_shift_cnt (w_cons_hw),
    .i_app_cnt   (w_app_cnt),
    .i_app_data  (w_app_data),
    .o_hw0       (w_hw0),
    .o_hw1       (w_hw1),
    .o_count     (w_count)
  );

  // Head decode, handshakes, and what the buffer should drop and take this cycle.
  always_comb begin
    w_compressed  = f_is_compressed(w_hw0, C_CEXT);
    w_avail       = ((w_count >= 2'd1) && w_compressed) || (w_count >= 2'd2);
    o_valid       = w_avail && !i_redirect;
    o_compressed  = w_avail && w_compressed;
    o_opcode      = 32'h0;
    if (w_avail) o_opcode = w_compressed ? {16'h0000, w_hw0} : {w_hw1, w_hw0};
    w_consume     = o_valid && i_ready;
    w_cons_hw     = w_consume ? f_inst_len_hw(w_hw0, C_CEXT) : 2'd0;
    o_fetch_ready = (w_count - w_cons_hw) <= 2'd1;
    w_xfer        = i_fetch_valid && o_fetch_ready && !i_redirect;
    w_app_cnt     = 2'd0;
    if (w_xfer) w_app_cnt = r_skip ? 2'd1 : 2'd2;
    w_app_data    = r_skip ? {16'h0000, i_fetch_data[31:16]} : i_fetch_data;
    w_redir_head  = C_CEXT ? {i_redirect_pc[31:1], 1'b0} : {i_redirect_pc[31:2], 2'b00};
  end

  // PC, fetch address and skip tracking; a redirect overrides everything else.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head_pc    <= P_RESET_PC & ~32'h3;
      r_fetch_addr <= P_RESET_PC & ~32'h3;
      r_skip       <= 1'b0;
    end else if (i_redirect) begin
      r_head_pc    <= w_redir_head;
      r_fetch_addr <= {i_redirect_pc[31:2], 2'b00};
      r_skip       <= C_CEXT && i_redirect_pc[1];
    end else begin
      if (w_consume) r_head_pc <= r_head_pc + (w_compressed ? 32'd2 : 32'd4);
      if (w_xfer) begin
        r_fetch_addr <= r_fetch_addr + 32'd4;
        r_skip       <= 1'b0;
      end
    end
  end

  assign o_pc         = r_head_pc;
  assign o_fetch_addr = r_fetch_addr;

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
Sits directly upstream of the instruction decoder. It accepts word-aligned 32-bit fetch data and tracks the fetch PC. It handles a mixed stream of 16-bit (RVC) and 32-bit instructions, including 32-bit instructions that straddle a word boundary, and presents one whole instruction at a time on o_opcode/o_pc with a valid/ready handshake. Redirects from branch/jump resolution flush it and restart fetch at any halfword-aligned PC.

Parameters:
P_RESET_PC, 32'h0000_0000, fetch PC after reset.
P_C_EXT, 1, RVC support; tied to the C_EXTENSION config define at instantiation. When 0, every instruction is 32-bit and PC bit 1 is ignored.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  reset, asynchronous, active-low.
o_fetch_addr  out  32  word-aligned fetch address; bits [1:0] always 0.
i_fetch_data  in  32  fetch data for o_fetch_addr in the same cycle.
i_fetch_valid  in  1  fetch data valid.
o_fetch_ready  out  1  aligner can absorb a word this cycle.
i_redirect  in  1  flush and restart.
i_redirect_pc  in  32  new PC; bit 0 ignored.
o_opcode  out  32  head instruction; [31:16]=0 when compressed.
o_pc  out  32  PC of o_opcode.
o_compressed  out  1  head instruction is 16-bit.
o_valid  out  1  o_opcode/o_pc valid.
i_ready  in  1  decode stage accepts the instruction.

Behaviour:
- Storage: 3-halfword buffer hw[0..2] (hw[0] = head), count 0..3, head_pc register, fetch_addr register, skip flag.
- Reset (async, i_rst_n=0):
  - count=0, skip=0, head_pc=fetch_addr=P_RESET_PC & ~3.
  - o_valid=0, o_opcode=0, o_compressed=0, o_fetch_ready=1.
- Word transfer: fires when i_fetch_valid && o_fetch_ready && !i_redirect.
  - The two halfwords are appended at index count (low half first), and fetch_addr += 4.
  - If skip=1, the low halfword is dropped, only the high one is appended, and skip clears.
- Head decode:
  - compressed = P_C_EXT && hw[0][1:0]!=2'b11.
  - avail = (count>=1 && compressed) || count>=2.
  - o_valid = avail && !i_redirect.
  - o_opcode = compressed ? {16'h0, hw[0]} : {hw[1], hw[0]}.
- Consume: fires when o_valid && i_ready.
  - The buffer shifts by 1 (compressed) or 2 halfwords.
  - head_pc += 2 (compressed) or 4.
- Simultaneous consume and transfer: shift first, then append. The buffer must never overflow.
- o_fetch_ready = (count - consumed_halfwords) <= 1, computed combinationally from i_ready. Holding 3 halfwords with no consume gives ready=0.
- Latency: a word transferred in cycle N can be presented on o_opcode in cycle N+1 at the earliest. No combinational path from i_fetch_data to o_opcode.
- Straddle: count=1 and hw[0][1:0]==11 gives o_valid=0 until the next word arrives.
- Redirect has priority over transfer and consume in the same cycle:
  - count=0.
  - head_pc = {i_redirect_pc[31:1],1'b0}.
  - fetch_addr = {i_redirect_pc[31:2],2'b00}.
  - skip = P_C_EXT && i_redirect_pc[1].
  - Fetch data arriving in the redirect cycle is discarded.
- P_C_EXT=0: redirect bit 1 is treated as 0 and skip stays 0.
- Backpressure: while i_ready=0, o_opcode, o_pc and o_compressed stay stable once o_valid=1, until consumed or redirected.
- A 16'h0000 halfword is passed through as compressed; illegal-instruction handling belongs to the decoder.
- PC and address arithmetic is mod 2^32; wraps from 32'hFFFF_FFFC to 0 silently.

Decomposition:
- Shared package/config: reset PC default, halfword width (16), RVC quadrant-3 constant 2'b11, instruction-length helper function.
- One natural sub-module, `halfword_buffer`: 3-entry shift buffer with append/shift-by-1/2 and count.
- The aligner top holds the PC, address, skip and handshake logic.

Test Plan:
1. Reset with P_RESET_PC=0, fetch words 0x00A00513, 0x00B00593 -> o_pc 0x0 then 0x4, o_compressed=0, opcodes as fetched.
2. Words 0x05130505, 0x000100A0 -> pc 0x0 op 0x00000505 (C); pc 0x2 op 0x00A00513 (straddle); pc 0x6 op 0x00000001 (C).
3. i_redirect with pc 0x102 -> next o_fetch_addr 0x100; with data 0x45014581, first o_pc 0x102, op 0x00004501.
4. i_ready=0 for 5 cycles with 3 halfwords buffered -> o_fetch_ready=0, o_opcode/o_pc held; on i_ready=1, consumption resumes with no lost halfword.
5. Redirect in the same cycle as i_fetch_valid and i_ready -> that data is dropped, no consume occurs, o_valid=0 that cycle, fetch_addr equals the redirect word.
6. i_rst_n pulled low mid-stream (count=2) -> o_valid=0 immediately (async); o_fetch_addr=P_RESET_PC after release.
